// File: rtl/grf_pkg.sv
// grf_pkg -- shared definitions for the multi-port general register file.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_ADDR_W  default register width and address width
//   ZERO_REG                         hard-wired zero register index
//   TRACE_FMT                        write trace format (used when GRF_TRACE_EN is defined)
//   pendDelta()                      +1/-1/0 contribution of one pending bit transition
package grf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int ZERO_REG       = 0;

    localparam string TRACE_FMT = "%d@%h: $%d <= %h";

    // Net change of the pending count caused by one register's bit going from
    // wasPending to isPending across an edge.
    function automatic logic signed [1:0] pendDelta(input logic wasPending,
                                                    input logic isPending);
        case ({wasPending, isPending})
            2'b01:   return 2'sd1;
            2'b10:   return -2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// grf_scoreboard -- pending-write scoreboard for the general register file.
//
// Tracks one pending bit per register: set by an issued producer, cleared by
// a retiring (wr_clr) write. A set and a clear of the same register on the
// same edge leave the bit set, because the newly issued producer supersedes
// the retiring one. pending_cnt_o is a registered counter kept equal to the
// popcount of the pending bits.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   issue_valid_i    an instruction with a destination issues this cycle
//   issue_addr_i     its destination register
//   we_i, wr_clr_i   per write port: write enable, retire pending entry
//   wr_addr_i        per write port address (packed)
//   rd_addr_i        per read port address (packed)
//   rd_busy_o        per read port: register has an outstanding producer
//   pending_cnt_o    number of registers currently pending
module grf_scoreboard
    import grf_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid_i,
    input  logic [ADDR_W-1:0]        issue_addr_i,
    input  logic [NUM_WR-1:0]        we_i,
    input  logic [NUM_WR-1:0]        wr_clr_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic [ADDR_W:0]          pending_cnt_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0]        pending_q, pending_d;
    logic [DEPTH-1:0]        clrHit;
    logic [ADDR_W:0]         cnt_q, cnt_d;
    logic signed [ADDR_W+1:0] delta;

    // Registers being retired this cycle by any clearing write port.
    always_comb begin
        clrHit = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (we_i[w] && wr_clr_i[w]) begin
                clrHit[wr_addr_i[w*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // Next pending bits (set beats clear) and the net count change. Register
    // zero is skipped so it can never become pending.
    always_comb begin
        pending_d = '0;
        delta     = '0;
        for (int r = 1; r < DEPTH; r++) begin
            pending_d[r] = (issue_valid_i && (issue_addr_i == ADDR_W'(r)))
                         | (pending_q[r] & ~clrHit[r]);
            delta = delta + (ADDR_W+2)'(pendDelta(pending_q[r], pending_d[r]));
        end
        cnt_d = cnt_q + (ADDR_W+1)'(delta);
    end

    // Scoreboard state; reset drops every outstanding producer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // A clearing write in the current cycle hides the pending bit so decode
    // can consume the bypassed value without stalling.
    always_comb begin
        rd_busy_o = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_busy_o[k] = (rd_addr_i[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                         && pending_q[rd_addr_i[k*ADDR_W +: ADDR_W]]
                         && !clrHit[rd_addr_i[k*ADDR_W +: ADDR_W]];
        end
    end

    assign pending_cnt_o = cnt_q;

endmodule

// File: rtl/grf_multiport.sv
// grf_multiport -- parametrised multi-port general register file.
//
// Holds the register array, resolves write-port priority (higher index wins)
// and provides combinational reads with same-cycle bypass from all write
// ports. Hazard bookkeeping lives in grf_scoreboard.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset (clears array and scoreboard)
//   rd_addr       NUM_RD packed read addresses
//   rd_data       NUM_RD packed read data
//   rd_busy       NUM_RD pending-write flags for the read addresses
//   we, wr_addr, wr_data, wr_clr, wr_pc   NUM_WR packed write ports
//   issue_valid, issue_addr               destination of the issuing instruction
//   pending_cnt   number of pending registers
//
// Configuration macro:
//   GRF_TRACE_EN  when defined, prints one trace line per enabled write port
//                 on each rising edge outside reset.
module grf_multiport
    import grf_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_WR-1:0]        wr_clr,
    input  logic [NUM_WR*32-1:0]     wr_pc,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          pending_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rdData;

    // Register array. Ports are applied in index order so the last
    // non-blocking assignment (highest port) wins on an address collision.
    // Entry zero is never written and therefore always reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we[w] && (wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))) begin
                    mem_q[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read muxes: array value, overridden by matching write ports in
    // ascending index order so the highest-priority writer is forwarded.
    always_comb begin
        rdData = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rdData[k*DATA_W +: DATA_W] = mem_q[rd_addr[k*ADDR_W +: ADDR_W]];
            for (int w = 0; w < NUM_WR; w++) begin
                if (we[w]
                    && (wr_addr[w*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG))
                    && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
                    rdData[k*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign rd_data = rdData;

    grf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .issue_valid_i (issue_valid),
        .issue_addr_i  (issue_addr),
        .we_i          (we),
        .wr_clr_i      (wr_clr),
        .wr_addr_i     (wr_addr),
        .rd_addr_i     (rd_addr),
        .rd_busy_o     (rd_busy),
        .pending_cnt_o (pending_cnt)
    );

`ifdef GRF_TRACE_EN
    // Write trace, including writes aimed at register zero.
    always @(posedge clk) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (we[w]) begin
                    $display(TRACE_FMT, $time, wr_pc[w*32 +: 32],
                             wr_addr[w*ADDR_W +: ADDR_W], wr_data[w*DATA_W +: DATA_W]);
                end
            end
        end
    end
`else
    // The PC only feeds the trace; fold it away when tracing is off.
    logic unusedPc;
    assign unusedPc = ^wr_pc;
`endif

endmodule

// File: tb/tb_grf_multiport.sv
// tb_grf_multiport -- directed self-checking bench for grf_multiport
// (two read ports, two write ports, 32 x 32-bit registers).
module tb_grf_multiport;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_WR-1:0]        wr_clr;
    logic [NUM_WR*32-1:0]     wr_pc;
    logic                     issue_valid;
    logic [ADDR_W-1:0]        issue_addr;
    logic [ADDR_W:0]          pending_cnt;

    logic [ADDR_W-1:0] rdAddr0, rdAddr1, wrAddr0, wrAddr1;
    logic [DATA_W-1:0] wrData0, wrData1;

    int checkCount = 0;
    int errorCount = 0;

    assign rd_addr = {rdAddr1, rdAddr0};
    assign wr_addr = {wrAddr1, wrAddr0};
    assign wr_data = {wrData1, wrData0};
    assign wr_pc   = {32'h0040_3004, 32'h0040_3000};

    always #5 clk = ~clk;

    grf_multiport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_clr      (wr_clr),
        .wr_pc       (wr_pc),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .pending_cnt (pending_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drop all write and issue activity; read addresses are left alone.
    task automatic applyStimulus();
        we          = '0;
        wr_clr      = '0;
        wrAddr0     = '0;
        wrAddr1     = '0;
        wrData0     = '0;
        wrData1     = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
    endtask

    task automatic writePort(input int p, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic clr);
        if (p == 0) begin
            wrAddr0 = a; wrData0 = d;
        end else begin
            wrAddr1 = a; wrData1 = d;
        end
        we[p]     = 1'b1;
        wr_clr[p] = clr;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
    endtask

    // Advance one edge, then idle the inputs just after it.
    task automatic tick();
        @(posedge clk);
        #1;
        applyStimulus();
    endtask

    initial begin
        reset   = 1'b1;
        rdAddr0 = 5'd9;
        rdAddr1 = 5'd0;
        applyStimulus();

        // Activity during reset must be discarded.
        writePort(0, 5'd9, 32'h0000_0099, 1'b0);
        issue(5'd9);
        #2;
        checkOutput("reset_cnt", 32'(pending_cnt), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        checkOutput("reset_write_dropped", rd_data[31:0], 32'h0);
        checkOutput("reset_issue_dropped", 32'(pending_cnt), 32'd0);
        tick();

        // Write $5 and issue $7, then assert reset asynchronously mid-cycle.
        rdAddr0 = 5'd5;
        rdAddr1 = 5'd7;
        writePort(0, 5'd5, 32'h0000_1234, 1'b0);
        issue(5'd7);
        #1;
        checkOutput("bypass_r5", rd_data[31:0], 32'h0000_1234);
        tick();
        #1;
        checkOutput("array_r5", rd_data[31:0], 32'h0000_1234);
        checkOutput("cnt_before_reset", 32'(pending_cnt), 32'd1);
        checkOutput("busy_r7", 32'(rd_busy[1]), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_r5", rd_data[31:0], 32'h0);
        checkOutput("async_reset_cnt", 32'(pending_cnt), 32'd0);
        checkOutput("async_reset_busy", 32'(rd_busy[1]), 32'd0);
        #1;
        reset = 1'b0;
        tick();

        // Both ports write $8: port 1 has priority.
        rdAddr0 = 5'd8;
        rdAddr1 = 5'd8;
        writePort(0, 5'd8, 32'h0000_AAAA, 1'b0);
        writePort(1, 5'd8, 32'h0000_BBBB, 1'b0);
        #1;
        checkOutput("prio_bypass_p0", rd_data[31:0], 32'h0000_BBBB);
        checkOutput("prio_bypass_p1", rd_data[63:32], 32'h0000_BBBB);
        tick();
        #1;
        checkOutput("prio_array", rd_data[31:0], 32'h0000_BBBB);

        // Issue $3 (cycle n); busy from n+1.
        rdAddr0 = 5'd3;
        rdAddr1 = 5'd0;
        issue(5'd3);
        #1;
        checkOutput("issue_busy_same_cycle", 32'(rd_busy[0]), 32'd0);
        tick();
        #1;
        checkOutput("issue_busy_n1", 32'(rd_busy[0]), 32'd1);
        checkOutput("issue_cnt_n1", 32'(pending_cnt), 32'd1);

        // Cycle n+1: clearing write to $0 is ignored entirely.
        writePort(0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        #1;
        checkOutput("r0_read", rd_data[63:32], 32'h0);
        checkOutput("r0_busy", 32'(rd_busy[1]), 32'd0);
        checkOutput("r0_cnt", 32'(pending_cnt), 32'd1);
        tick();
        #1;
        checkOutput("r0_read_after", rd_data[63:32], 32'h0);
        checkOutput("r0_cnt_after", 32'(pending_cnt), 32'd1);
        tick();
        tick();

        // Cycle n+4: clearing write to $3 on port 1.
        writePort(1, 5'd3, 32'h0000_CAFE, 1'b1);
        #1;
        checkOutput("clr_busy_bypass", 32'(rd_busy[0]), 32'd0);
        checkOutput("clr_data_bypass", rd_data[31:0], 32'h0000_CAFE);
        checkOutput("clr_cnt_before_edge", 32'(pending_cnt), 32'd1);
        tick();
        #1;
        checkOutput("clr_cnt_n5", 32'(pending_cnt), 32'd0);
        checkOutput("clr_busy_n5", 32'(rd_busy[0]), 32'd0);
        checkOutput("clr_data_n5", rd_data[31:0], 32'h0000_CAFE);

        // Set and clear of the same pending register: set wins.
        issue(5'd3);
        tick();
        #1;
        checkOutput("reissue_cnt", 32'(pending_cnt), 32'd1);
        issue(5'd3);
        writePort(0, 5'd3, 32'h0000_0033, 1'b1);
        #1;
        checkOutput("setclr_busy_bypass", 32'(rd_busy[0]), 32'd0);
        checkOutput("setclr_data", rd_data[31:0], 32'h0000_0033);
        tick();
        #1;
        checkOutput("setclr_busy_after", 32'(rd_busy[0]), 32'd1);
        checkOutput("setclr_cnt_after", 32'(pending_cnt), 32'd1);

        // Issue $4 while retiring $3: net count unchanged.
        rdAddr1 = 5'd4;
        issue(5'd4);
        writePort(0, 5'd3, 32'h0000_0044, 1'b1);
        tick();
        #1;
        checkOutput("swap_cnt", 32'(pending_cnt), 32'd1);
        checkOutput("swap_r3_free", 32'(rd_busy[0]), 32'd0);
        checkOutput("swap_r4_busy", 32'(rd_busy[1]), 32'd1);
        writePort(0, 5'd4, 32'h0000_0004, 1'b1);
        tick();
        #1;
        checkOutput("swap_drain_cnt", 32'(pending_cnt), 32'd0);

        // Fill every nonzero register, one issue per cycle.
        for (int r = 1; r < 32; r++) begin
            issue(ADDR_W'(r));
            tick();
            #1;
            checkOutput($sformatf("fill_cnt_%0d", r), 32'(pending_cnt), 32'(r));
        end
        issue(5'd5);
        tick();
        #1;
        checkOutput("fill_repeat_cnt", 32'(pending_cnt), 32'd31);

        // Drain two registers per cycle.
        for (int i = 0; i < 16; i++) begin
            writePort(0, ADDR_W'(2*i + 1), 32'(i), 1'b1);
            if (2*i + 2 < 32) begin
                writePort(1, ADDR_W'(2*i + 2), 32'(i), 1'b1);
            end
            tick();
            #1;
            checkOutput($sformatf("drain_cnt_%0d", i), 32'(pending_cnt),
                        (31 - 2*(i + 1) > 0) ? 32'(31 - 2*(i + 1)) : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/grf_multiport.md
# grf_multiport

Parametrised general-purpose register file for the pipelined MIPS core: configurable width, depth, read-port and write-port count, with same-cycle write-to-read bypass across all write ports and a pending-write scoreboard. Decode reads operands and queries hazards through it; writeback (and any additional late-result ports) write into it. It replaces the fixed two-read/one-write GRF and moves hazard bookkeeping out of the stall unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2); higher index = higher priority
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears array and scoreboard
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k register has an outstanding pending write
- we  in  NUM_WR  write enable per write port
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- wr_clr  in  NUM_WR  this write retires the scoreboard entry for wr_addr
- wr_pc  in  NUM_WR*32  PC of the writing instruction (trace only)
- issue_valid  in  1  an instruction with a destination is issued this cycle
- issue_addr  in  ADDR_W  destination of the issued instruction
- pending_cnt  out  ADDR_W+1  number of registers currently marked pending

## Operation
- Register 0 reads 0 always; writes to address 0 ignored, never marked pending.
- Write: on rising clk, for each port with we=1 and wr_addr!=0, array[wr_addr] <= wr_data. Two ports, same address: port 1 wins.
- Read (combinational): rd_data[k] = wr_data of highest-priority port with we=1, wr_addr==rd_addr[k], wr_addr!=0; else array[rd_addr[k]].
- Scoreboard: one pending bit per register. issue_valid with issue_addr!=0 sets bit on next edge. we=1 and wr_clr=1 clears bit of wr_addr on next edge.
- Same-edge set and clear of same address: set wins (new producer supersedes retiring one).
- Repeated issue to an already-pending address: bit stays set, no count change.
- rd_busy[k] = pending[rd_addr[k]] AND NOT (a port with we=1, wr_clr=1, wr_addr==rd_addr[k] this cycle); address 0 never busy.
- pending_cnt = popcount of pending bits, maintained as a registered counter (+1 per set of clear bit, -1 per clear of set bit, net per edge); must equal popcount at all times.

## Timing
- Reset (async assert): all registers 0, all pending bits 0, pending_cnt 0, effective immediately; rd_data reflects 0 for non-bypassed reads, rd_busy 0. Writes/issues during reset are discarded.
- Read latency 0 (combinational); write visible via bypass in same cycle, via array from next cycle.
- issue -> rd_busy asserted from cycle after issue; clearing write -> rd_busy deasserts in the same cycle (bypass) and pending bit falls at the edge.
- No handshake; ports sample every edge. Caller guarantees at most one issue per cycle.

## Configuration
- GRF_TRACE_EN defined: on each rising clk outside reset, for each write port in index order with we=1, $display("%d@%h: $%d <= %h", $time, wr_pc, wr_addr, wr_data), including address 0 writes (matches grader log format).
- Undefined: no display statements compiled; functional behaviour identical.

## Structure
- Package grf_pkg: default DATA_W/ADDR_W, ZERO_REG constant, popcount-delta function, trace format string.
- Sub-module grf_scoreboard: pending bits, set/clear precedence, pending_cnt counter, rd_busy generation; top holds array, write priority and bypass muxes.

## Test plan
- Reset mid-run after writing $5=0x1234: assert reset asynchronously -> rd_data for $5 = 0 before next edge, pending_cnt=0.
- NUM_WR=2, both ports write $8 (0xAAAA port0, 0xBBBB port1) -> same-cycle read $8 = 0xBBBB; next cycle array read = 0xBBBB.
- Write $0=0xFFFF_FFFF with wr_clr -> read $0 = 0, rd_busy 0, pending_cnt unchanged; trace line printed when GRF_TRACE_EN.
- Issue $3 at cycle n -> rd_busy for $3 = 1 at n+1, pending_cnt=1; clearing write to $3 at n+4 -> rd_busy 0 and rd_data = write data in cycle n+4, pending_cnt=0 at n+5.
- Same cycle issue $3 and clearing write $3 (already pending) -> bit stays 1, pending_cnt unchanged; issue $4 while clearing $3 -> pending_cnt unchanged, $4 busy, $3 free.
- Issue all 31 nonzero registers -> pending_cnt=31; clear all with two ports per cycle -> count decrements by 2 per cycle to 0.
